// File: rtl/mdu_unit.sv
// mdu_unit: EX-stage multiply/divide unit that holds the architectural HI/LO
// registers. Operands and the opcode are latched at issue, and the unit stays
// busy for a fixed number of cycles. The result is written to HI/LO on the
// edge where busy falls.
// Optional build macro MDU_MADD_EN enables MADD/MADDU, which accumulate into
// {HI,LO}. When the macro is not defined, opcodes 7 and 8 behave as NONE.
module mdu_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_mul, is_div, is_madd, is_md;
   logic [63:0] prod_s, prod_u;
   logic        div_signed;
   logic [31:0] dvd, dvs, uquo, urem, quo, rem;
`ifdef MDU_MADD_EN
   logic [63:0] acc_s, acc_u;
`endif

   // Decode the incoming opcode into the multi-cycle op classes.
   always_comb begin
      is_mul  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
      is_div  = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
`ifdef MDU_MADD_EN
      is_madd = (MDUOp == OP_MADD) || (MDUOp == OP_MADDU);
`else
      is_madd = 1'b0;
`endif
      is_md   = is_mul || is_div || is_madd;
   end

   // Compute the arithmetic results from the latched operands only.
   // The signed divide runs on magnitudes, so 0x80000000 / -1 wraps cleanly.
   always_comb begin
      prod_u     = {32'd0, a_q} * {32'd0, b_q};
      prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      div_signed = (op_q == OP_DIV);
      dvd        = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
      dvs        = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
      if (dvs == 32'd0) begin
         uquo = '0;
         urem = '0;
      end else begin
         uquo = dvd / dvs;
         urem = dvd % dvs;
      end
      quo = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - uquo) : uquo;
      rem = (div_signed && a_q[31]) ? (32'd0 - urem) : urem;
`ifdef MDU_MADD_EN
      acc_s = {hi_q, lo_q} + prod_s;
      acc_u = {hi_q, lo_q} + prod_u;
`endif
   end

   // Next-state logic: issue from IDLE, count down in RUN, write HI/LO on exit.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (is_md) begin
                  a_d     = A;
                  b_d     = B;
                  op_d    = op_e'(MDUOp);
                  cnt_d   = is_div ? DIV_CYCLES : MULT_CYCLES;
                  state_d = RUN;
               end else if (MDUOp == OP_MTHI) begin
                  hi_d = A;
               end else if (MDUOp == OP_MTLO) begin
                  lo_d = A;
               end
            end
         end
         RUN: begin
            if (cnt_q == 32'd1) begin
               state_d = IDLE;
               cnt_d   = '0;
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  OP_DIV, OP_DIVU: begin
                     if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                     end
                  end
`ifdef MDU_MADD_EN
                  OP_MADD:  {hi_d, lo_d} = acc_s;
                  OP_MADDU: {hi_d, lo_d} = acc_u;
`endif
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register. Reset wins over everything and drops any op in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_NONE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign stall_req = (start && is_md) || busy;
   assign HI        = hi_q;
   assign LO        = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed-vector bench for mdu_unit with hand-computed results.
module tb_mdu_unit;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  MDUOp = 4'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy, stall_req;
   logic [31:0] HI, LO;

   int checks = 0;
   int failures = 0;
   int n;

   mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
      .A(A), .B(B), .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present an op for one cycle. The operands are scrambled afterwards so a
   // DUT that does not latch them produces wrong results.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_stall);
      @(negedge clk);
      start = 1'b1; MDUOp = op; A = a; B = b;
      #1 check("stall_on_issue", 64'(stall_req), 64'(exp_stall));
      @(negedge clk);
      start = 1'b0; MDUOp = 4'd0; A = 32'hDEADBEEF; B = 32'h0BADF00D;
   endtask

   // Count busy cycles starting from the current sample point. The count is bounded.
   task automatic count_busy(input int base, output int cnt);
      cnt = base;
      while (busy && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_stall", 64'(stall_req), 64'd0);
      check("reset_hi", 64'(HI), 64'd0);
      check("reset_lo", 64'(LO), 64'd0);

      // MULT: -2 * 3 = -6
      issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
      check("mult_stall_busy", 64'(stall_req), 64'd1);
      count_busy(0, n);
      check("mult_busy_cycles", 64'(n), 64'(MC));
      check("mult_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);

      // MULTU: 0xFFFFFFFF * 2
      issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1);
      count_busy(0, n);
      check("multu_busy_cycles", 64'(n), 64'(MC));
      check("multu_hilo", {HI, LO}, 64'h00000001_FFFFFFFE);

      // DIV: -7 / 2 -> q=-3, r=-1
      issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
      count_busy(0, n);
      check("div_busy_cycles", 64'(n), 64'(DC));
      check("div_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);

      // DIV overflow case: 0x80000000 / -1
      issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      count_busy(0, n);
      check("div_ovf_hilo", {HI, LO}, 64'h00000000_80000000);

      // DIVU: 100 / 7 -> q=14, r=2
      issue(4'd4, 32'd100, 32'd7, 1'b1);
      count_busy(0, n);
      check("divu_hilo", {HI, LO}, 64'h00000002_0000000E);

      // MTHI: a read in the same cycle still sees the old HI
      @(negedge clk);
      start = 1'b1; MDUOp = 4'd5; A = 32'h12345678;
      #1 check("mthi_stall", 64'(stall_req), 64'd0);
      check("mthi_same_cycle_hi", 64'(HI), 64'h2);
      @(negedge clk);
      start = 1'b0; MDUOp = 4'd0; A = '0;
      check("mthi_hi", 64'(HI), 64'h12345678);
      check("mthi_busy", 64'(busy), 64'd0);

      issue(4'd6, 32'hCAFEF00D, 32'd0, 1'b0);
      check("mtlo_lo", 64'(LO), 64'hCAFEF00D);

      // DIVU by zero, with an MTLO issued on busy cycle 3 that must be ignored
      issue(4'd4, 32'd7, 32'd0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; MDUOp = 4'd6; A = 32'h55555555;
      @(negedge clk);
      start = 1'b0; MDUOp = 4'd0; A = '0;
      check("divz_stall_busy", 64'(stall_req), 64'd1);
      count_busy(3, n);
      check("divz_busy_cycles", 64'(n), 64'(DC));
      check("divz_hilo", {HI, LO}, 64'h12345678_CAFEF00D);

      // NONE and an undefined opcode have no effect
      issue(4'd0, 32'h11111111, 32'h22222222, 1'b0);
      check("none_busy", 64'(busy), 64'd0);
      issue(4'd15, 32'h11111111, 32'h22222222, 1'b0);
      check("undef_busy", 64'(busy), 64'd0);
      check("undef_hilo", {HI, LO}, 64'h12345678_CAFEF00D);

      // MADDU / MADD, starting from {HI,LO} = 0x0_FFFFFFFF
      issue(4'd5, 32'd0, 32'd0, 1'b0);
      issue(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
      issue(4'd8, 32'd1, 32'd1, 1'b1);
      count_busy(0, n);
      check("maddu_busy_cycles", 64'(n), 64'(MC));
      check("maddu_hilo", {HI, LO}, 64'h00000001_00000000);
      issue(4'd7, 32'hFFFFFFFF, 32'd1, 1'b1);
      count_busy(0, n);
      check("madd_hilo", {HI, LO}, 64'h00000000_FFFFFFFF);
`else
      issue(4'd8, 32'd1, 32'd1, 1'b0);
      check("maddu_off_busy", 64'(busy), 64'd0);
      repeat (MC + 1) @(negedge clk);
      check("maddu_off_hilo", {HI, LO}, 64'h00000000_FFFFFFFF);
`endif

      // Reset on busy cycle 4 of a DIV discards the op
      issue(4'd3, 32'd100, 32'd3, 1'b1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_hilo", {HI, LO}, 64'd0);
      repeat (DC + 2) @(negedge clk);
      check("rst_no_late_write", {HI, LO}, 64'd0);
      check("rst_no_late_busy", 64'(busy), 64'd0);

      // Unit still operates after the mid-op reset
      issue(4'd2, 32'd6, 32'd7, 1'b1);
      count_busy(0, n);
      check("post_rst_multu", {HI, LO}, 64'd42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
